// File: rtl/uart_pkg.sv
// Shared UART definitions for the receiver and transmitter.
//   uart_state_e : receiver FSM states (StParity exists only when UART_RX_PARITY_EN is defined)
//   OVERSAMPLE   : s_tick strobes per bit period
//   MID_SAMPLE   : s_tick count at which the start bit is re-checked (mid-bit)
// Optional feature macro: UART_RX_PARITY_EN.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_SAMPLE = 7;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop
  } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset, both flops reset to 1 (idle line level)
//   d_i     : asynchronous input
//   q_o     : synchronized output
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling.
//   clk          : rising-edge clock
//   reset_n      : asynchronous active-low reset
//   s_tick       : one-clk strobe at 16x baud
//   rx           : asynchronous serial line, idle high, LSB first
//   rx_dout      : last received word (held until the next completed frame)
//   rx_done_tick : one-clk pulse when a frame completes, aligned with rx_dout update
//   frame_err    : stop bit was sampled low on the last frame
//   parity_err   : (UART_RX_PARITY_EN only) parity mismatch on the last frame
// Optional feature macro: UART_RX_PARITY_EN adds a parity bit between data and stop,
// the PARITY_ODD parameter and the parity_err output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit          PARITY_ODD = 1'b0
`endif
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] rx_dout,
  output logic            rx_done_tick,
  output logic            frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic            parity_err
`endif
);

  localparam int unsigned SW = $clog2(SB_TICK);
  localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] SMid  = SW'(MID_SAMPLE);
  localparam logic [SW-1:0] SBit  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SStop = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] NLast = NW'(DBIT - 1);

  logic rx_s;

  sync_2ff u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (rx),
    .q_o     (rx_s)
  );

  uart_state_e     state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            ferr_q, ferr_d;
  logic            done_q, done_d;
`ifdef UART_RX_PARITY_EN
  logic            par_bit_q, par_bit_d;
  logic            perr_q, perr_d;
`endif

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    dout_d  = dout_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d = par_bit_q;
    perr_d    = perr_q;
`endif

    case (state_q)
      StIdle: begin
        s_d = '0;
        if (!rx_s) state_d = StStart;
      end

      StStart: begin
        if (s_tick) begin
          if (s_q == SMid) begin
            s_d = '0;
            if (!rx_s) begin
              state_d = StData;
              n_d     = '0;
            end else begin
              // Line went back high before mid-bit: treat as a glitch.
              state_d = StIdle;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      StData: begin
        if (s_tick) begin
          if (s_q == SBit) begin
            s_d = '0;
            b_d = {rx_s, b_q[DBIT-1:1]};
            if (n_q == NLast) begin
`ifdef UART_RX_PARITY_EN
              state_d = StParity;
`else
              state_d = StStop;
`endif
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (s_tick) begin
          if (s_q == SBit) begin
            s_d       = '0;
            par_bit_d = rx_s;
            state_d   = StStop;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`endif

      StStop: begin
        if (s_tick) begin
          if (s_q == SStop) begin
            s_d     = '0;
            dout_d  = b_q;
            ferr_d  = ~rx_s;
            done_d  = 1'b1;
            state_d = StIdle;
`ifdef UART_RX_PARITY_EN
            perr_d  = ^b_q ^ par_bit_q ^ PARITY_ODD;
`endif
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = StIdle;
        s_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      ferr_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      dout_q  <= dout_d;
      ferr_q  <= ferr_d;
      done_q  <= done_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q <= par_bit_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign rx_dout      = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err   = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: 8 data bits, 1 stop bit, s_tick every 4 clk
// (one bit period = 64 clk). Parity scenarios are built only with UART_RX_PARITY_EN.
module tb_uart_rx;

  localparam int BitClks = 64;

  logic       clk;
  logic       reset_n;
  logic       s_tick;
  logic       rx;
  logic [7:0] rx_dout;
  logic       rx_done_tick;
  logic       frame_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  logic       par_flip;
`endif

  int vectors;
  int miscompares;
  int done_cnt;
  logic [7:0] got_q[$];

  uart_rx #(
    .DBIT    (8),
    .SB_TICK (16)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_tick       (s_tick),
    .rx           (rx),
    .rx_dout      (rx_dout),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err   (parity_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // s_tick generator: one clk high out of every four.
  initial begin
    int cnt;
    cnt    = 0;
    s_tick = 1'b0;
    forever begin
      @(negedge clk);
      s_tick = (cnt == 3);
      cnt    = (cnt + 1) % 4;
    end
  end

  // Completion monitor: counts high cycles of rx_done_tick and records the word.
  initial begin
    done_cnt = 0;
    forever begin
      @(negedge clk);
      if (rx_done_tick === 1'b1) begin
        done_cnt++;
        got_q.push_back(rx_dout);
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int stop_clks);
    rx = 1'b0;
    wait_clks(BitClks);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      wait_clks(BitClks);
    end
`ifdef UART_RX_PARITY_EN
    rx = ^data ^ par_flip;
    wait_clks(BitClks);
`endif
    rx = stop_bit;
    wait_clks(stop_clks);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    rx      = 1'b1;
    wait_clks(5);
    vectors++;
    if (rx_dout !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_dout: got %h want 00", rx_dout);
    end
    vectors++;
    if (frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ferr: got %b want 0", frame_err);
    end
    vectors++;
    if (rx_done_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_done: got %b want 0", rx_done_tick);
    end
`ifdef UART_RX_PARITY_EN
    vectors++;
    if (parity_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_perr: got %b want 0", parity_err);
    end
`endif
    reset_n = 1'b1;
    wait_clks(20);
  endtask

  task automatic test_basic();
    int c0;
    c0 = done_cnt;
    send_frame(8'hA5, 1'b1, BitClks);
    wait_clks(40);
    vectors++;
    if (done_cnt - c0 !== 1) begin
      miscompares++;
      $display("FAIL basic_pulses: got %0d want 1", done_cnt - c0);
    end
    vectors++;
    if (rx_dout !== 8'hA5) begin
      miscompares++;
      $display("FAIL basic_dout: got %h want a5", rx_dout);
    end
    vectors++;
    if (frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_ferr: got %b want 0", frame_err);
    end
  endtask

  task automatic test_glitch();
    int c0;
    c0 = done_cnt;
    rx = 1'b0;
    wait_clks(20);  // five s_tick periods
    rx = 1'b1;
    wait_clks(3 * BitClks);
    vectors++;
    if (done_cnt - c0 !== 0) begin
      miscompares++;
      $display("FAIL glitch_pulses: got %0d want 0", done_cnt - c0);
    end
    vectors++;
    if (rx_dout !== 8'hA5) begin
      miscompares++;
      $display("FAIL glitch_dout: got %h want a5", rx_dout);
    end
    vectors++;
    if (frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_ferr: got %b want 0", frame_err);
    end
  endtask

  task automatic test_idle_ticks();
    int c0;
    c0 = done_cnt;
    wait_clks(300);
    vectors++;
    if (done_cnt - c0 !== 0) begin
      miscompares++;
      $display("FAIL idle_pulses: got %0d want 0", done_cnt - c0);
    end
    vectors++;
    if (rx_dout !== 8'hA5) begin
      miscompares++;
      $display("FAIL idle_dout: got %h want a5", rx_dout);
    end
  endtask

  task automatic test_frame_err();
    int c0;
    c0 = done_cnt;
    // Stop bit stays low past its mid-bit sample, then the line returns high.
    send_frame(8'h3C, 1'b0, 48);
    wait_clks(3 * BitClks);
    vectors++;
    if (done_cnt - c0 !== 1) begin
      miscompares++;
      $display("FAIL ferr_pulses: got %0d want 1", done_cnt - c0);
    end
    vectors++;
    if (rx_dout !== 8'h3C) begin
      miscompares++;
      $display("FAIL ferr_dout: got %h want 3c", rx_dout);
    end
    vectors++;
    if (frame_err !== 1'b1) begin
      miscompares++;
      $display("FAIL ferr_flag: got %b want 1", frame_err);
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    int q0;
    logic [7:0] exp_v[3];
    exp_v[0] = 8'h00;
    exp_v[1] = 8'hFF;
    exp_v[2] = 8'h55;
    c0 = done_cnt;
    q0 = got_q.size();
    for (int i = 0; i < 3; i++) send_frame(exp_v[i], 1'b1, BitClks);
    wait_clks(40);
    vectors++;
    if (done_cnt - c0 !== 3) begin
      miscompares++;
      $display("FAIL b2b_pulses: got %0d want 3", done_cnt - c0);
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (q0 + i >= got_q.size()) begin
        miscompares++;
        $display("FAIL b2b_word%0d: got none want %h", i, exp_v[i]);
      end else if (got_q[q0+i] !== exp_v[i]) begin
        miscompares++;
        $display("FAIL b2b_word%0d: got %h want %h", i, got_q[q0+i], exp_v[i]);
      end
    end
    vectors++;
    if (frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_ferr: got %b want 0", frame_err);
    end
  endtask

  task automatic test_reset_abort();
    int c0;
    logic [7:0] d;
    d  = 8'h81;
    c0 = done_cnt;
    rx = 1'b0;
    wait_clks(BitClks);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      wait_clks(BitClks);
    end
    rx = d[4];
    wait_clks(BitClks / 2);
    reset_n = 1'b0;
    rx      = 1'b1;
    wait_clks(2);
    vectors++;
    if (rx_dout !== 8'h00) begin
      miscompares++;
      $display("FAIL abort_reset_dout: got %h want 00", rx_dout);
    end
    wait_clks(18);
    reset_n = 1'b1;
    wait_clks(2 * BitClks);
    vectors++;
    if (done_cnt - c0 !== 0) begin
      miscompares++;
      $display("FAIL abort_pulses: got %0d want 0", done_cnt - c0);
    end
    send_frame(8'h42, 1'b1, BitClks);
    wait_clks(40);
    vectors++;
    if (done_cnt - c0 !== 1) begin
      miscompares++;
      $display("FAIL abort_next_pulses: got %0d want 1", done_cnt - c0);
    end
    vectors++;
    if (rx_dout !== 8'h42) begin
      miscompares++;
      $display("FAIL abort_next_dout: got %h want 42", rx_dout);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    // 0x07 has three ones, so even parity expects a parity bit of 1.
    par_flip = 1'b1;  // line carries parity bit 0
    send_frame(8'h07, 1'b1, BitClks);
    wait_clks(40);
    vectors++;
    if (parity_err !== 1'b1) begin
      miscompares++;
      $display("FAIL parity_bad: got %b want 1", parity_err);
    end
    par_flip = 1'b0;  // line carries parity bit 1
    send_frame(8'h07, 1'b1, BitClks);
    wait_clks(40);
    vectors++;
    if (parity_err !== 1'b0) begin
      miscompares++;
      $display("FAIL parity_good: got %b want 0", parity_err);
    end
    vectors++;
    if (rx_dout !== 8'h07) begin
      miscompares++;
      $display("FAIL parity_dout: got %h want 07", rx_dout);
    end
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    rx          = 1'b1;
`ifdef UART_RX_PARITY_EN
    par_flip    = 1'b0;
`endif
    test_reset();
    test_basic();
    test_glitch();
    test_idle_ticks();
    test_frame_err();
    test_back_to_back();
    test_reset_abort();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DBIT, 8, data bits per frame (5..9).
REQ-002 SHALL have parameter SB_TICK, 16, s_tick count for the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-003 SHALL have port clk input 1, rising-edge clock.
REQ-004 SHALL have port reset_n input 1, asynchronous active-low reset.
REQ-005 SHALL have port s_tick input 1, one-clk strobe at 16x baud.
REQ-006 SHALL have port rx input 1, asynchronous serial line, idle high.
REQ-007 SHALL have port rx_dout output DBIT, last received word, LSB first on the line.
REQ-008 SHALL have port rx_done_tick output 1, one-clk pulse when a frame completes.
REQ-009 SHALL have port frame_err output 1, stop-bit-low flag for the last frame.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer; all FSM decisions use the synchronized value (rx_s).
REQ-011 SHALL implement states IDLE, START, DATA, STOP (plus PARITY, see REQ-022).
REQ-012 IDLE: s counter cleared; rx_s==0 -> START; s_tick is not required to leave IDLE.
REQ-013 START: s increments on each s_tick; at s==7 with s_tick: rx_s==0 -> DATA, s=0, n=0; rx_s==1 -> IDLE (glitch rejection, no output change).
REQ-014 DATA: at s==15 with s_tick: s=0, shift register b={rx_s, b[DBIT-1:1]}; n==DBIT-1 -> STOP, else n++.
REQ-015 STOP: at s==SB_TICK-1 with s_tick: rx_dout<=b, frame_err<=~rx_s, rx_done_tick=1 for that clk, -> IDLE.
REQ-016 Counter widths: s SHALL cover SB_TICK-1; n SHALL cover DBIT-1; no wrap inside a state.
REQ-017 rx_dout and frame_err SHALL be registered and hold until the next completed frame; a frame aborted in START does not modify them.
REQ-018 A framing error SHALL still deliver data and pulse rx_done_tick.
REQ-019 Back-to-back frames: a start edge on the clk after STOP exit SHALL be accepted.
REQ-020 Ticks without data-line activity SHALL leave all outputs unchanged.

Reset
REQ-021 reset_n low SHALL immediately force state IDLE, s=0, n=0, b=0, rx_dout=0, rx_done_tick=0, frame_err=0 (parity_err=0 when present), and synchronizer flops=1; a frame in flight is discarded, and reception resumes on the first falling edge after release.

Configuration
REQ-022 With UART_RX_PARITY_EN defined: output parity_err (1 bit) and parameter PARITY_ODD (default 0) SHALL exist; state PARITY between DATA and STOP samples one bit at s==15; parity_err<=(^b ^ rx_s ^ PARITY_ODD) is registered alongside rx_dout. Without the macro: no port, no state, DATA -> STOP directly.

Structure
REQ-023 Package uart_pkg SHALL hold the state enum typedef and the OVERSAMPLE=16 and MID_SAMPLE=7 constants, shared with the transmitter.
REQ-024 The synchronizer SHALL be a sub-module sync_2ff (1-bit, reset value 1).

Verification
REQ-025 Send 0xA5 with 8N1, s_tick every 4 clk -> one rx_done_tick, rx_dout=0xA5, frame_err=0.
REQ-026 Pulse rx low for 5 s_ticks, then high -> FSM returns to IDLE; no rx_done_tick; rx_dout unchanged.
REQ-027 Send 0x3C with stop bit held low -> rx_dout=0x3C, frame_err=1, rx_done_tick pulses once.
REQ-028 Send 0x00, 0xFF, 0x55 back-to-back with no idle gap -> three pulses, values in order.
REQ-029 Assert reset_n low during data bit 4 of 0x81, then send 0x42 -> rx_dout=0x42; no pulse for the aborted frame.
REQ-030 With UART_RX_PARITY_EN and PARITY_ODD=0, send 0x07 with parity bit 0 -> parity_err=1; with parity bit 1 -> parity_err=0.
